// File: rtl/dmem_router_pkg.sv
// Shared constants and types for the data-side router: request encodings,
// bus widths, router state encoding, response codes and the default CLINT
// window. Every router file imports this package.
package dmem_router_pkg;

    localparam int DATA_W      = 64;
    localparam int DATA_ADDR_W = 64;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [1:0] ROUTER_IDLE = 2'd0;
    localparam logic [1:0] ROUTER_REQ  = 2'd1;
    localparam logic [1:0] ROUTER_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [DATA_ADDR_W-1:0] CLINT_BASE = 64'h0000_0000_0200_0000;
    localparam logic [DATA_ADDR_W-1:0] CLINT_MASK = 64'h0000_0000_FFFF_0000;

    // One captured LSU access, held stable for the whole REQ state.
    typedef struct packed {
        logic                   req;
        logic [DATA_ADDR_W-1:0] addr;
        logic [1:0]             size;
        logic [DATA_W-1:0]      wdata;
    } dmem_req_t;

    // True when the masked address bits match the window base.
    function automatic logic addr_in_window(
        input logic [DATA_ADDR_W-1:0] addr,
        input logic [DATA_ADDR_W-1:0] base,
        input logic [DATA_ADDR_W-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/dmem_router_decode.sv
// Combinational address-region decoder for the data router.
// Latency: none (pure combinational). Backpressure: not applicable.
// Ports: addr in; sel_clint out (1 = address falls in the CLINT window,
// 0 = everything else goes to the AXI bridge). New targets are added here.
module dmem_router_decode
    import dmem_router_pkg::*;
#(
    parameter logic [DATA_ADDR_W-1:0] WIN_BASE = CLINT_BASE,
    parameter logic [DATA_ADDR_W-1:0] WIN_MASK = CLINT_MASK
) (
    input  logic [DATA_ADDR_W-1:0] addr,
    output logic                   sel_clint
);

    assign sel_clint = addr_in_window(addr, WIN_BASE, WIN_MASK);

endmodule

// File: rtl/dmem_router.sv
// Data-side router: LSU access -> exactly one of CLINT / AXI bridge, one access in flight.
// Latency: accept in cycle 0, target valid from cycle 1, lsu_ready one cycle after target ready (min 3 cycles).
// Backpressure: target valid held with stable fields until ready or TIMEOUT; lsu_valid ignored outside IDLE.
// Ports: clk/rst (async active-high); lsu_* request in / completion out
// (lsu_ready is a one-cycle pulse carrying data_read, resp and skip);
// clint_* and axi_* carry the forwarded request out and the response back.
module dmem_router
    import dmem_router_pkg::*;
#(
    parameter logic [DATA_ADDR_W-1:0] CLINT_BASE_P = CLINT_BASE,
    parameter logic [DATA_ADDR_W-1:0] CLINT_MASK_P = CLINT_MASK,
    parameter logic [15:0]            TIMEOUT      = 16'd1023
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   lsu_valid,
    input  logic                   lsu_req,
    input  logic [DATA_ADDR_W-1:0] lsu_addr,
    input  logic [1:0]             lsu_size,
    input  logic [DATA_W-1:0]      lsu_data_write,
    output logic                   lsu_ready,
    output logic [DATA_W-1:0]      lsu_data_read,
    output logic [1:0]             lsu_resp,
    output logic                   lsu_skip,

    output logic                   clint_valid,
    output logic                   clint_req,
    output logic [DATA_ADDR_W-1:0] clint_addr,
    output logic [1:0]             clint_size,
    output logic [DATA_W-1:0]      clint_data_write,
    input  logic                   clint_ready,
    input  logic [DATA_W-1:0]      clint_data_read,
    input  logic [1:0]             clint_resp,

    output logic                   axi_valid,
    output logic                   axi_req,
    output logic [DATA_ADDR_W-1:0] axi_addr,
    output logic [1:0]             axi_size,
    output logic [DATA_W-1:0]      axi_data_write,
    input  logic                   axi_ready,
    input  logic [DATA_W-1:0]      axi_data_read,
    input  logic [1:0]             axi_resp
);

    logic [1:0]        state_q,     state_d;
    dmem_req_t         cap_q,       cap_d;
    logic              sel_clint_q, sel_clint_d;
    logic [15:0]       cnt_q,       cnt_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic [1:0]        resp_q,      resp_d;

    logic              dec_sel_clint;
    logic              tgt_ready;
    logic [DATA_W-1:0] tgt_rdata;
    logic [1:0]        tgt_resp;
    logic              in_req;
    logic              in_resp;

    dmem_router_decode #(
        .WIN_BASE (CLINT_BASE_P),
        .WIN_MASK (CLINT_MASK_P)
    ) u_decode (
        .addr      (lsu_addr),
        .sel_clint (dec_sel_clint)
    );

    assign in_req  = (state_q == ROUTER_REQ);
    assign in_resp = (state_q == ROUTER_RESP);

    // Response mux follows the target latched at accept time, not the live address.
    assign tgt_ready = sel_clint_q ? clint_ready     : axi_ready;
    assign tgt_rdata = sel_clint_q ? clint_data_read : axi_data_read;
    assign tgt_resp  = sel_clint_q ? clint_resp      : axi_resp;

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        sel_clint_d = sel_clint_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        case (state_q)
            ROUTER_IDLE: begin
                if (lsu_valid) begin
                    state_d     = ROUTER_REQ;
                    cap_d.req   = lsu_req;
                    cap_d.addr  = lsu_addr;
                    cap_d.size  = lsu_size;
                    cap_d.wdata = lsu_data_write;
                    sel_clint_d = dec_sel_clint;
                    cnt_d       = 16'd0;
                end
            end
            ROUTER_REQ: begin
                // Ready wins over timeout when both land in the same cycle.
                if (tgt_ready) begin
                    state_d = ROUTER_RESP;
                    rdata_d = (cap_q.req == REQ_WRITE) ? '0 : tgt_rdata;
                    resp_d  = tgt_resp;
                end else if (cnt_q >= TIMEOUT) begin
                    // TIMEOUT=0 errors out in the very first REQ cycle.
                    state_d = ROUTER_RESP;
                    rdata_d = '0;
                    resp_d  = RESP_SLVERR;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ROUTER_RESP: begin
                // Always return to IDLE; a still-high lsu_valid is taken next cycle.
                state_d = ROUTER_IDLE;
            end
            default: begin
                state_d = ROUTER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ROUTER_IDLE;
            cap_q       <= '0;
            sel_clint_q <= 1'b0;
            cnt_q       <= 16'd0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            sel_clint_q <= sel_clint_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    // All outputs decode from the async-reset state register, so they drop
    // as soon as rst rises. The unselected target sees all-zero fields.
    assign clint_valid      = in_req & sel_clint_q;
    assign clint_req        = sel_clint_q ? cap_q.req   : 1'b0;
    assign clint_addr       = sel_clint_q ? cap_q.addr  : '0;
    assign clint_size       = sel_clint_q ? cap_q.size  : 2'd0;
    assign clint_data_write = sel_clint_q ? cap_q.wdata : '0;

    assign axi_valid        = in_req & ~sel_clint_q;
    assign axi_req          = sel_clint_q ? 1'b0 : cap_q.req;
    assign axi_addr         = sel_clint_q ? '0   : cap_q.addr;
    assign axi_size         = sel_clint_q ? 2'd0 : cap_q.size;
    assign axi_data_write   = sel_clint_q ? '0   : cap_q.wdata;

    assign lsu_ready        = in_resp;
    assign lsu_data_read    = in_resp ? rdata_q : '0;
    assign lsu_resp         = in_resp ? resp_q  : RESP_OKAY;
    assign lsu_skip         = in_resp & sel_clint_q;

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: small CLINT and AXI target models, pulse
// monitors, and a linear sequence of accesses with hand-computed results.
module tb_dmem_router;
    import dmem_router_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   lsu_valid = 1'b0;
    logic                   lsu_req = 1'b0;
    logic [DATA_ADDR_W-1:0] lsu_addr = '0;
    logic [1:0]             lsu_size = 2'd3;
    logic [DATA_W-1:0]      lsu_data_write = '0;
    logic                   lsu_ready;
    logic [DATA_W-1:0]      lsu_data_read;
    logic [1:0]             lsu_resp;
    logic                   lsu_skip;

    logic                   clint_valid, clint_req, clint_ready;
    logic [DATA_ADDR_W-1:0] clint_addr;
    logic [1:0]             clint_size, clint_resp;
    logic [DATA_W-1:0]      clint_data_write, clint_data_read;

    logic                   axi_valid, axi_req, axi_ready;
    logic [DATA_ADDR_W-1:0] axi_addr;
    logic [1:0]             axi_size, axi_resp;
    logic [DATA_W-1:0]      axi_data_write, axi_data_read;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_router #(.TIMEOUT(16'd8)) dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_valid        (lsu_valid),
        .lsu_req          (lsu_req),
        .lsu_addr         (lsu_addr),
        .lsu_size         (lsu_size),
        .lsu_data_write   (lsu_data_write),
        .lsu_ready        (lsu_ready),
        .lsu_data_read    (lsu_data_read),
        .lsu_resp         (lsu_resp),
        .lsu_skip         (lsu_skip),
        .clint_valid      (clint_valid),
        .clint_req        (clint_req),
        .clint_addr       (clint_addr),
        .clint_size       (clint_size),
        .clint_data_write (clint_data_write),
        .clint_ready      (clint_ready),
        .clint_data_read  (clint_data_read),
        .clint_resp       (clint_resp),
        .axi_valid        (axi_valid),
        .axi_req          (axi_req),
        .axi_addr         (axi_addr),
        .axi_size         (axi_size),
        .axi_data_write   (axi_data_write),
        .axi_ready        (axi_ready),
        .axi_data_read    (axi_data_read),
        .axi_resp         (axi_resp)
    );

    // CLINT model: always ready; mtimecmp at BASE+0x4000, other offsets read 0x55.
    logic [63:0] mtimecmp_q = 64'd0;
    assign clint_ready     = 1'b1;
    assign clint_resp      = 2'b00;
    assign clint_data_read = (clint_addr == 64'h0200_4000) ? mtimecmp_q : 64'h55;
    always @(posedge clk)
        if (clint_valid && clint_ready && clint_req == REQ_WRITE && clint_addr == 64'h0200_4000)
            mtimecmp_q <= clint_data_write;

    // AXI model: ready on the axi_delay-th valid cycle, or never when axi_never=1.
    int   axi_delay = 1;
    logic axi_never = 1'b0;
    int   axi_wait  = 0;
    assign axi_ready     = axi_valid && !axi_never && (axi_wait == axi_delay - 1);
    assign axi_resp      = 2'b00;
    assign axi_data_read = 64'hDEAD_BEEF;
    always @(posedge clk)
        if (axi_valid && !axi_ready) axi_wait <= axi_wait + 1;
        else                         axi_wait <= 0;

    // Monotonic monitors; steps compare deltas.
    int          n_clint = 0, n_axi = 0, n_rdy = 0, n_unstable = 0;
    logic        prev_av = 1'b0;
    logic [63:0] prev_aa = '0;
    always @(posedge clk) begin
        if (clint_valid) n_clint <= n_clint + 1;
        if (axi_valid)   n_axi   <= n_axi + 1;
        if (lsu_ready)   n_rdy   <= n_rdy + 1;
        if (axi_valid && prev_av && axi_addr != prev_aa) n_unstable <= n_unstable + 1;
        prev_av <= axi_valid;
        prev_aa <= axi_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access and wait (bounded) for lsu_ready; lat counts cycles from accept.
    task automatic access(input logic rq, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic [1:0] rs,
                          output logic sk, output int lat);
        @(negedge clk);
        lsu_valid      = 1'b1;
        lsu_req        = rq;
        lsu_addr       = a;
        lsu_size       = 2'd3;
        lsu_data_write = wd;
        lat = -1;
        rd  = '0;
        rs  = 2'b11;
        sk  = 1'bx;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (lsu_ready) begin
                lat = i;
                rd  = lsu_data_read;
                rs  = lsu_resp;
                sk  = lsu_skip;
                break;
            end
        end
        lsu_valid = 1'b0;
    endtask

    logic [63:0] rd;
    logic [1:0]  rs;
    logic        sk;
    int          lat, c0, a0, r0, u0, t1, gap;

    initial begin
        // Reset state
        #12;
        check("rst_lsu_ready",   {63'd0, lsu_ready},   64'd0);
        check("rst_clint_valid", {63'd0, clint_valid}, 64'd0);
        check("rst_axi_valid",   {63'd0, axi_valid},   64'd0);
        check("rst_data",        lsu_data_read,        64'd0);
        check("rst_resp",        {62'd0, lsu_resp},    64'd0);
        check("rst_skip",        {63'd0, lsu_skip},    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // CLINT write mtimecmp = 0x100
        c0 = n_clint; a0 = n_axi;
        access(REQ_WRITE, 64'h0200_4000, 64'h100, rd, rs, sk, lat);
        check("cw_lat",   lat,          2);
        check("cw_rdata", rd,           64'd0);
        check("cw_skip",  {63'd0, sk},  64'd1);
        check("cw_pulse", n_clint - c0, 1);

        // CLINT read back
        c0 = n_clint; a0 = n_axi;
        access(REQ_READ, 64'h0200_4000, 64'h0, rd, rs, sk, lat);
        check("cr_lat",   lat,          2);
        check("cr_rdata", rd,           64'h100);
        check("cr_resp",  {62'd0, rs},  64'd0);
        check("cr_skip",  {63'd0, sk},  64'd1);
        check("cr_pulse", n_clint - c0, 1);
        check("cr_noaxi", n_axi - a0,   0);

        // AXI read with ready on the 5th valid cycle
        axi_delay = 5;
        a0 = n_axi; u0 = n_unstable;
        access(REQ_READ, 64'h8000_0000, 64'h0, rd, rs, sk, lat);
        check("ar_axi_cycles", n_axi - a0,      5);
        check("ar_lat",        lat,             6);
        check("ar_rdata",      rd,              64'hDEAD_BEEF);
        check("ar_resp",       {62'd0, rs},     64'd0);
        check("ar_skip",       {63'd0, sk},     64'd0);
        check("ar_addr_stable", n_unstable - u0, 0);
        axi_delay = 1;

        // Boundary decode
        c0 = n_clint; a0 = n_axi;
        access(REQ_READ, 64'h0200_FFF8, 64'h0, rd, rs, sk, lat);
        check("bd_top_clint", n_clint - c0, 1);
        check("bd_top_noaxi", n_axi - a0,   0);
        check("bd_top_data",  rd,           64'h55);
        check("bd_top_skip",  {63'd0, sk},  64'd1);
        c0 = n_clint; a0 = n_axi;
        access(REQ_READ, 64'h0201_0000, 64'h0, rd, rs, sk, lat);
        check("bd_above_axi",   n_axi - a0,   1);
        check("bd_above_clint", n_clint - c0, 0);
        check("bd_above_skip",  {63'd0, sk},  64'd0);
        c0 = n_clint; a0 = n_axi;
        access(REQ_READ, 64'h01FF_FFF8, 64'h0, rd, rs, sk, lat);
        check("bd_below_axi",   n_axi - a0,   1);
        check("bd_below_clint", n_clint - c0, 0);
        check("bd_below_data",  rd,           64'hDEAD_BEEF);

        // Timeout: ready never comes, TIMEOUT=8 -> 9 REQ cycles
        axi_never = 1'b1;
        a0 = n_axi;
        access(REQ_READ, 64'h8000_0010, 64'h0, rd, rs, sk, lat);
        check("to_lat",        lat,         10);
        check("to_axi_cycles", n_axi - a0,  9);
        check("to_resp",       {62'd0, rs}, 64'h2);
        check("to_rdata",      rd,          64'd0);
        check("to_skip",       {63'd0, sk}, 64'd0);
        axi_never = 1'b0;
        access(REQ_READ, 64'h8000_0020, 64'h0, rd, rs, sk, lat);
        check("to_next_lat",   lat,         2);
        check("to_next_rdata", rd,          64'hDEAD_BEEF);
        check("to_next_resp",  {62'd0, rs}, 64'd0);

        // AXI write returns zero read data even though the bridge drives data
        access(REQ_WRITE, 64'h8000_0030, 64'h1234, rd, rs, sk, lat);
        check("aw_rdata", rd,  64'd0);
        check("aw_lat",   lat, 2);

        // Back-to-back CLINT writes with lsu_valid held high throughout
        @(negedge clk);
        c0 = n_clint; r0 = n_rdy;
        lsu_valid = 1'b1; lsu_req = REQ_WRITE; lsu_addr = 64'h0200_4000; lsu_data_write = 64'h111;
        t1 = -1; gap = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (lsu_ready) begin t1 = i; break; end
        end
        lsu_data_write = 64'h222;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (lsu_ready) begin gap = i; break; end
        end
        lsu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_first_lat",  t1,           2);
        check("b2b_gap",        gap,          3);
        check("b2b_clint_puls", n_clint - c0, 2);
        check("b2b_rdy_pulses", n_rdy - r0,   2);
        check("b2b_mtimecmp",   mtimecmp_q,   64'h222);

        // Reset in the middle of a stalled AXI access
        axi_never = 1'b1;
        @(negedge clk);
        lsu_valid = 1'b1; lsu_req = REQ_READ; lsu_addr = 64'h8000_0040;
        @(negedge clk);
        @(negedge clk);
        check("mr_axi_before", {63'd0, axi_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_axi_async",   {63'd0, axi_valid},   64'd0);
        check("mr_ready_async", {63'd0, lsu_ready},   64'd0);
        check("mr_clint_async", {63'd0, clint_valid}, 64'd0);
        check("mr_data_async",  lsu_data_read,        64'd0);
        lsu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        axi_never = 1'b0;
        axi_delay = 1;
        c0 = n_clint; a0 = n_axi;
        access(REQ_READ, 64'h0200_4000, 64'h0, rd, rs, sk, lat);
        check("mr_after_lat",   lat,          2);
        check("mr_after_rdata", rd,           64'h222);
        check("mr_after_skip",  {63'd0, sk},  64'd1);
        check("mr_after_clint", n_clint - c0, 1);
        check("mr_after_noaxi", n_axi - a0,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
